// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX resolve and statistics signals of the branch predictor
interface branch_predictor_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] if_pc, pred_target, ex_pc, ex_target, ex_pred_target, redirect_pc;
    logic pred_taken, ex_valid, ex_is_branch, ex_taken, ex_pred_taken, mispredict;
    logic [31:0] branch_cnt, mispred_cnt;
    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispred_cnt
    );
    modport slave (
        input if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, EX-stage resolve and statistics
module branch_predictor #(
    parameter int XLEN = 32,
    parameter int ENTRIES = 16
) (
    input logic clk,
    input logic rst,
    branch_predictor_if.slave bp
);
    localparam int IB = $clog2(ENTRIES);
    localparam int TW = XLEN - IB - 2;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT = 2'b10;
    logic [ENTRIES-1:0] valid;
    logic [TW-1:0] tag [ENTRIES];
    logic [XLEN-1:0] target [ENTRIES];
    logic [1:0] ctr [ENTRIES];
    logic [IB-1:0] if_idx, ex_idx;
    logic [TW-1:0] if_tag, ex_tag;
    logic if_hit, ex_hit, resolve, alias_hit;
    logic [1:0] ctr_cur, ctr_nx;
    logic [31:0] br_cnt, mp_cnt;
    assign if_idx = bp.if_pc[IB+1:2];
    assign if_tag = bp.if_pc[XLEN-1:IB+2];
    assign ex_idx = bp.ex_pc[IB+1:2];
    assign ex_tag = bp.ex_pc[XLEN-1:IB+2];
    always_comb begin
        if_hit = valid[if_idx] && tag[if_idx] == if_tag;
        ex_hit = valid[ex_idx] && tag[ex_idx] == ex_tag;
        resolve = bp.ex_valid && bp.ex_is_branch;
        alias_hit = bp.ex_valid && !bp.ex_is_branch && bp.ex_pred_taken;
        ctr_cur = ctr[ex_idx];
        ctr_nx = bp.ex_taken ? (ctr_cur == 2'b11 ? ctr_cur : ctr_cur + 2'b01)
                             : (ctr_cur == 2'b00 ? ctr_cur : ctr_cur - 2'b01);
        bp.pred_taken = if_hit && ctr[if_idx][1];
        bp.pred_target = bp.pred_taken ? target[if_idx] : bp.if_pc + XLEN'(4);
        bp.mispredict = alias_hit || (resolve && (bp.ex_taken != bp.ex_pred_taken ||
                        (bp.ex_taken && bp.ex_target != bp.ex_pred_target)));
        bp.redirect_pc = (resolve && bp.ex_taken) ? bp.ex_target : bp.ex_pc + XLEN'(4);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            br_cnt <= '0;
            mp_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i] <= '0;
                target[i] <= '0;
                ctr[i] <= WNT;
            end
        end else begin
            if (resolve && ex_hit) begin
                ctr[ex_idx] <= ctr_nx;
                if (bp.ex_taken) target[ex_idx] <= bp.ex_target;
            end else if (resolve && bp.ex_taken) begin
                valid[ex_idx] <= 1'b1;
                tag[ex_idx] <= ex_tag;
                target[ex_idx] <= bp.ex_target;
                ctr[ex_idx] <= WT;
            end else if (alias_hit && ex_hit) begin
                valid[ex_idx] <= 1'b0;
            end
            if (resolve && br_cnt != '1) br_cnt <= br_cnt + 32'd1;
            if (bp.mispredict && mp_cnt != '1) mp_cnt <= mp_cnt + 32'd1;
        end
    end
    assign bp.branch_cnt = br_cnt;
    assign bp.mispred_cnt = mp_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed sequence with an expected-value scoreboard checked by immediate assertions
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    branch_predictor_if #(.XLEN(32)) bp ();
    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (.clk(clk), .rst(rst), .bp(bp));
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic push_exp(string t, logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic got(logic [31:0] v);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: got %h expected none", v);
        end else begin
            e = sb.pop_front();
            assert (v === e.val) else begin
                n_fail++;
                $error("FAIL %s: got %h expected %h", e.tag, v, e.val);
            end
        end
    endtask

    task automatic drive(logic v, logic b, logic [31:0] pc, logic t, logic [31:0] tg, logic pt, logic [31:0] ptg);
        bp.ex_valid = v;
        bp.ex_is_branch = b;
        bp.ex_pc = pc;
        bp.ex_taken = t;
        bp.ex_target = tg;
        bp.ex_pred_taken = pt;
        bp.ex_pred_target = ptg;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic see_ex(string s, logic mp, logic [31:0] rpc);
        #1;
        push_exp({s, ".mispredict"}, 32'(mp));
        if (mp) push_exp({s, ".redirect_pc"}, rpc);
        got(32'(bp.mispredict));
        if (mp) got(bp.redirect_pc);
    endtask

    task automatic see_if(string s, logic [31:0] pc, logic pt, logic [31:0] ptg);
        bp.if_pc = pc;
        #1;
        push_exp({s, ".pred_taken"}, 32'(pt));
        push_exp({s, ".pred_target"}, ptg);
        got(32'(bp.pred_taken));
        got(bp.pred_target);
    endtask

    task automatic see_cnt(string s, logic [31:0] b, logic [31:0] m);
        #1;
        push_exp({s, ".branch_cnt"}, b);
        push_exp({s, ".mispred_cnt"}, m);
        got(bp.branch_cnt);
        got(bp.mispred_cnt);
    endtask

    initial begin
        bp.if_pc = 32'h100;
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
        tick();
        tick();
        rst = 1'b0;
        idle();
        see_if("reset", 32'h100, 1'b0, 32'h104);
        see_cnt("reset", 0, 0);
        see_ex("idle", 1'b0, 32'h0);
        see_if("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        see_ex("alloc", 1'b1, 32'h200);
        see_if("same_cycle", 32'h100, 1'b0, 32'h104);
        tick();
        drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        see_if("alloc", 32'h100, 1'b1, 32'h200);
        see_cnt("alloc", 1, 1);
        see_ex("nt1", 1'b1, 32'h104);
        tick();
        drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
        see_if("nt1", 32'h100, 1'b0, 32'h104);
        see_ex("nt2", 1'b0, 32'h0);
        tick();
        see_ex("nt3", 1'b0, 32'h0);
        tick();
        see_ex("nt4", 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        see_cnt("nt", 5, 2);
        see_ex("t1", 1'b1, 32'h200);
        tick();
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h220, 1'b0, 32'h104);
        see_if("snt_sat", 32'h100, 1'b0, 32'h104);
        see_ex("t2", 1'b1, 32'h220);
        tick();
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h220, 1'b1, 32'h220);
        see_if("t2", 32'h100, 1'b1, 32'h220);
        see_ex("t3", 1'b0, 32'h0);
        tick();
        see_ex("t4", 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h220);
        see_ex("nt5", 1'b1, 32'h104);
        tick();
        drive(1'b1, 1'b1, 32'h140, 1'b1, 32'h400, 1'b0, 32'h144);
        see_if("st_sat", 32'h100, 1'b1, 32'h220);
        see_ex("alias", 1'b1, 32'h400);
        tick();
        drive(1'b1, 1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h400);
        see_if("alias_old", 32'h100, 1'b0, 32'h104);
        see_if("alias_new", 32'h140, 1'b1, 32'h400);
        see_cnt("alias", 11, 6);
        see_ex("nonbranch", 1'b1, 32'h144);
        tick();
        drive(1'b1, 1'b0, 32'h140, 1'b0, 32'h0, 1'b0, 32'h144);
        see_if("invalidated", 32'h140, 1'b0, 32'h144);
        see_ex("nonbranch_np", 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 32'h184);
        see_ex("no_valid", 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h1C0, 1'b0, 32'h0, 1'b0, 32'h1C4);
        see_if("no_valid", 32'h180, 1'b0, 32'h184);
        see_cnt("no_valid", 11, 7);
        see_ex("nt_miss", 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 32'h184);
        see_if("nt_miss", 32'h1C0, 1'b0, 32'h1C4);
        see_ex("alloc180", 1'b1, 32'h500);
        tick();
        drive(1'b1, 1'b1, 32'h180, 1'b1, 32'h600, 1'b1, 32'h500);
        see_ex("bad_target", 1'b1, 32'h600);
        tick();
        idle();
        see_if("new_target", 32'h180, 1'b1, 32'h600);
        see_cnt("bad_target", 14, 9);
        force dut.br_cnt = 32'hFFFF_FFFE;
        force dut.mp_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.br_cnt;
        release dut.mp_cnt;
        drive(1'b1, 1'b1, 32'h180, 1'b0, 32'h0, 1'b1, 32'h600);
        see_ex("sat_mp", 1'b1, 32'h184);
        tick();
        see_cnt("sat1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        see_cnt("sat2", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h1C0, 1'b1, 32'h700, 1'b0, 32'h1C4);
        tick();
        rst = 1'b0;
        idle();
        see_cnt("reset2", 0, 0);
        see_if("reset2_a", 32'h180, 1'b0, 32'h184);
        see_if("reset2_b", 32'h1C0, 1'b0, 32'h1C4);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001: Parameter XLEN, default 32, datapath and PC width.
REQ-002: Parameter ENTRIES, default 16, table depth (power of two); IB = log2(ENTRIES).
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: if_pc  input  XLEN  fetch-stage PC to predict.
REQ-006: pred_taken  output  1  fetch prediction: redirect to pred_target.
REQ-007: pred_target  output  XLEN  predicted next fetch PC.
REQ-008: ex_valid  input  1  EX stage holds a valid instruction.
REQ-009: ex_is_branch  input  1  EX instruction is conditional (branch_src nonzero).
REQ-010: ex_pc  input  XLEN  PC of EX instruction.
REQ-011: ex_taken  input  1  resolved branch outcome from branch_control.
REQ-012: ex_target  input  XLEN  resolved taken target.
REQ-013: ex_pred_taken  input  1  prediction carried down the pipeline with the instruction.
REQ-014: ex_pred_target  input  XLEN  predicted target carried down the pipeline.
REQ-015: mispredict  output  1  flush IF/ID and redirect fetch this cycle.
REQ-016: redirect_pc  output  XLEN  correct next PC when mispredict=1.
REQ-017: branch_cnt  output  32  resolved conditional branches.
REQ-018: mispred_cnt  output  32  mispredictions.

Function
REQ-019: Per entry: valid (1), tag (XLEN-IB-2), target (XLEN), 2-bit counter; index = pc[IB+1:2], tag = pc[XLEN-1:IB+2].
REQ-020: Counter states SNT=00, WNT=01, WT=10, ST=11; predict taken iff counter[1]=1.
REQ-021: Lookup is combinational from registered tables: hit = valid && tag match; pred_taken = hit && counter[1]; pred_target = pred_taken ? stored target : if_pc+4 (mod 2^XLEN).
REQ-022: resolve = ex_valid && ex_is_branch; updates occur on the edge ending the resolve cycle.
REQ-023: On resolve with hit: counter +1 if ex_taken, -1 if not; saturates at ST and SNT; if ex_taken, target <= ex_target.
REQ-024: On resolve without hit and ex_taken: allocate entry (valid=1, new tag, target=ex_target, counter=WT).
REQ-025: On resolve without hit and not taken: no table write.
REQ-026: mispredict (combinational) = resolve && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
REQ-027: Also mispredict = 1 when ex_valid && !ex_is_branch && ex_pred_taken (aliased hit); that entry is invalidated (valid=0) at the edge if the tag matches ex_pc.
REQ-028: redirect_pc = (resolve && ex_taken) ? ex_target : ex_pc+4; value is don't-care when mispredict=0.
REQ-029: ex_valid=0 suppresses all updates, counting, and mispredict.
REQ-030: Same-index lookup and update in one cycle: lookup returns pre-update contents; new contents visible the next cycle.
REQ-031: branch_cnt increments by 1 per resolve; mispred_cnt increments by 1 per mispredict cycle; both saturate at 32'hFFFFFFFF.
REQ-032: Zero-latency: mispredict/redirect_pc valid in the same cycle as the EX inputs; table and counter effects visible one cycle later.

Reset
REQ-033: While rst=1 at a rising edge: all valid bits <= 0, all counters <= WNT, all targets/tags <= 0, branch_cnt <= 0, mispred_cnt <= 0.
REQ-034: rst takes priority over any simultaneous update; a resolve in the reset cycle is discarded.
REQ-035: After reset: pred_taken=0, pred_target=if_pc+4, mispredict follows only EX inputs.

Verification
REQ-036: Reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, branch_cnt=mispred_cnt=0.
REQ-037: Resolve ex_pc=0x100, taken, target=0x200, pred_taken=0 -> mispredict=1, redirect_pc=0x200; next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x200.
REQ-038: Four not-taken resolves at 0x100 after REQ-037 -> counter WT->WNT->SNT->SNT; pred_taken=0 from the first; mispred_cnt increments only when carried prediction differs.
REQ-039: Aliasing: ex_pc=0x140 (same index, different tag as 0x100) taken -> entry replaced; lookup 0x100 misses.
REQ-040: Non-branch with ex_pred_taken=1 at ex_pc=0x100 -> mispredict=1, redirect_pc=0x104, entry invalidated next cycle.
REQ-041: Assert rst during a resolve cycle -> no table write, counters 0; force branch_cnt near max -> saturates at 0xFFFFFFFF.
